// File: rtl/mx2_merge.sv
// Two-input Send/Ack packet merge/join stage: round-robin merge or ordered A-then-B join
// of two 4-phase input channels into one 4-phase output channel.
module mx2_merge #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         MR_n,
  input  logic         Send_a,
  input  logic [W-1:0] Data_a,
  output logic         Ack_a,
  input  logic         Send_b,
  input  logic [W-1:0] Data_b,
  output logic         Ack_b,
  input  logic         JNB,
  output logic         Send_out,
  output logic [W-1:0] Data_out,
  output logic         SEL_out,
  input  logic         Ack_in,
  output logic [1:0]   dbg_state
);

  // Handshakes are 4-phase: a sender raises Send with stable Data and holds it until Ack
  // rises, then drops Send; Ack falls after Send is seen low. The output side mirrors this
  // with Send_out/Ack_in, and Data_out/SEL_out stay stable while Send_out is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RTZ  = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] buf_a, buf_b;
  logic         full_a, full_b;
  logic         last_b;
  logic         join_ph;
  logic         clr_a, clr_b;
  logic         pick_valid, pick_b, pick_join;

  assign dbg_state = state;

  // The served buffer is released only when the output handshake returns to zero.
  assign clr_a = (state == RTZ) && !Ack_in && !SEL_out;
  assign clr_b = (state == RTZ) && !Ack_in &&  SEL_out;

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      Ack_a  <= 1'b0;
      full_a <= 1'b0;
      buf_a  <= '0;
    end else begin
      if (Send_a && !Ack_a && !full_a) begin
        buf_a  <= Data_a;
        full_a <= 1'b1;
        Ack_a  <= 1'b1;
      end else begin
        if (Ack_a && !Send_a) Ack_a <= 1'b0;
        if (clr_a) full_a <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      Ack_b  <= 1'b0;
      full_b <= 1'b0;
      buf_b  <= '0;
    end else begin
      if (Send_b && !Ack_b && !full_b) begin
        buf_b  <= Data_b;
        full_b <= 1'b1;
        Ack_b  <= 1'b1;
      end else begin
        if (Ack_b && !Send_b) Ack_b <= 1'b0;
        if (clr_b) full_b <= 1'b0;
      end
    end
  end

  // A started join pair always finishes with B, whatever JNB does in between.
  always_comb begin
    pick_valid = 1'b0;
    pick_b     = 1'b0;
    pick_join  = 1'b0;
    if (join_ph) begin
      pick_valid = full_b;
      pick_b     = 1'b1;
    end else if (JNB) begin
      pick_valid = full_a && full_b;
      pick_join  = 1'b1;
    end else if (full_a && full_b) begin
      pick_valid = 1'b1;
      pick_b     = !last_b;
    end else if (full_a) begin
      pick_valid = 1'b1;
    end else if (full_b) begin
      pick_valid = 1'b1;
      pick_b     = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      state    <= IDLE;
      Send_out <= 1'b0;
      Data_out <= '0;
      SEL_out  <= 1'b0;
      last_b   <= 1'b1;
      join_ph  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            Send_out <= 1'b1;
            Data_out <= pick_b ? buf_b : buf_a;
            SEL_out  <= pick_b;
            state    <= SEND;
            if (join_ph)        join_ph <= 1'b0;
            else if (pick_join) join_ph <= 1'b1;
            else                last_b  <= pick_b;
          end
        end
        SEND: begin
          if (Ack_in) begin
            Send_out <= 1'b0;
            state    <= RTZ;
          end
        end
        RTZ: begin
          if (!Ack_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mx2_merge.sv
// Self-checking bench for mx2_merge: reset, latency, table-driven merge/join vectors,
// backpressure and random 4-phase traffic against a per-channel scoreboard.
module tb_mx2_merge;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         MR_n;
  logic         Send_a, Send_b, JNB, Ack_in;
  logic [W-1:0] Data_a, Data_b;
  logic         Ack_a, Ack_b, Send_out, SEL_out;
  logic [W-1:0] Data_out;
  logic [1:0]   dbg_state;

  mx2_merge #(.W(W)) dut (
    .CLK(CLK), .MR_n(MR_n),
    .Send_a(Send_a), .Data_a(Data_a), .Ack_a(Ack_a),
    .Send_b(Send_b), .Data_b(Data_b), .Ack_b(Ack_b),
    .JNB(JNB),
    .Send_out(Send_out), .Data_out(Data_out), .SEL_out(SEL_out),
    .Ack_in(Ack_in), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0]   exp_q[$];
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic         per_ch = 1'b0;
  logic         cons_en = 1'b0;
  logic         rand_ack = 1'b0;
  int           ack_dly = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Output-side consumer: acks Send_out after ack_dly cycles, drops Ack_in once Send_out falls.
  initial begin
    int cnt;
    Ack_in = 1'b0;
    cnt = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (!MR_n) begin
        Ack_in = 1'b0;
        cnt = 0;
      end else if (Ack_in) begin
        if (!Send_out) Ack_in = 1'b0;
      end else if (Send_out && cons_en) begin
        if (cnt >= ack_dly) begin
          Ack_in = 1'b1;
          cnt = 0;
          if (rand_ack) ack_dly = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Monitor: every new output packet is scored; payload must stay stable while Send_out is high.
  initial begin
    logic         prev_send;
    logic [W:0]   got, held, e;
    logic [W-1:0] ed;
    prev_send = 1'b0;
    held = '0;
    forever begin
      @(posedge CLK);
      #1;
      got = {SEL_out, Data_out};
      if (Send_out && !prev_send) begin
        if (per_ch) begin
          if (!SEL_out) begin
            if (exp_a.size() == 0) fail_now("unexpected_out_a");
            else begin ed = exp_a.pop_front(); check("rand_out_a", 32'(Data_out), 32'(ed)); end
          end else begin
            if (exp_b.size() == 0) fail_now("unexpected_out_b");
            else begin ed = exp_b.pop_front(); check("rand_out_b", 32'(Data_out), 32'(ed)); end
          end
        end else if (exp_q.size() == 0) begin
          fail_now("unexpected_out");
        end else begin
          e = exp_q.pop_front();
          check("out_pkt", 32'(got), 32'(e));
        end
        held = got;
      end else if (Send_out && prev_send) begin
        check("out_stable", 32'(got), 32'(held));
      end
      prev_send = Send_out;
    end
  end

  task automatic put(input logic ch, input logic [W-1:0] d);
    int t;
    if (ch) begin Send_b = 1'b1; Data_b = d; end
    else    begin Send_a = 1'b1; Data_a = d; end
    t = 0;
    while (!(ch ? Ack_b : Ack_a) && t < 2000) begin tick(); t++; end
    if (t >= 2000) fail_now(ch ? "ack_b_rise" : "ack_a_rise");
    if (ch) Send_b = 1'b0; else Send_a = 1'b0;
    t = 0;
    while ((ch ? Ack_b : Ack_a) && t < 2000) begin tick(); t++; end
    if (t >= 2000) fail_now(ch ? "ack_b_fall" : "ack_a_fall");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0 ||
            Send_out || Ack_in || dbg_state != 2'd0) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) fail_now("drain");
  endtask

  task automatic do_reset();
    MR_n = 1'b0;
    Send_a = 1'b0; Send_b = 1'b0; Data_a = '0; Data_b = '0; JNB = 1'b0;
    exp_q.delete(); exp_a.delete(); exp_b.delete();
    tick(); tick();
    MR_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic         use_a, use_b;
    int           dly_a, dly_b;
    logic [W-1:0] da, db;
    logic         jnb;
    int           n_exp;
    logic [W:0]   e0, e1;
  } vec_t;

  vec_t vecs[8];

  initial begin
    MR_n = 1'b0;
    Send_a = 1'b0; Send_b = 1'b0; Data_a = '0; Data_b = '0; JNB = 1'b0;

    // Merge order follows round-robin state carried from one vector to the next.
    vecs[0] = '{1'b1, 1'b1, 0, 0, 16'h0001, 16'h0002, 1'b0, 2, {1'b0, 16'h0001}, {1'b1, 16'h0002}};
    vecs[1] = '{1'b1, 1'b1, 0, 0, 16'h0003, 16'h0004, 1'b0, 2, {1'b0, 16'h0003}, {1'b1, 16'h0004}};
    vecs[2] = '{1'b1, 1'b0, 0, 0, 16'h1111, 16'h0000, 1'b0, 1, {1'b0, 16'h1111}, 17'h0};
    vecs[3] = '{1'b0, 1'b1, 0, 0, 16'h0000, 16'h2222, 1'b0, 1, {1'b1, 16'h2222}, 17'h0};
    vecs[4] = '{1'b1, 1'b1, 0, 0, 16'h0AAA, 16'h0BBB, 1'b1, 2, {1'b0, 16'h0AAA}, {1'b1, 16'h0BBB}};
    vecs[5] = '{1'b1, 1'b1, 0, 0, 16'h0005, 16'h0006, 1'b0, 2, {1'b0, 16'h0005}, {1'b1, 16'h0006}};
    vecs[6] = '{1'b1, 1'b1, 3, 0, 16'h00C1, 16'h00C2, 1'b0, 2, {1'b1, 16'h00C2}, {1'b0, 16'h00C1}};
    vecs[7] = '{1'b1, 1'b1, 0, 0, 16'h0007, 16'h0008, 1'b0, 2, {1'b1, 16'h0008}, {1'b0, 16'h0007}};

    // Reset state
    tick(); tick();
    check("rst_send_out", 32'(Send_out), 32'd0);
    check("rst_data_out", 32'(Data_out), 32'd0);
    check("rst_ack_a", 32'(Ack_a), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    MR_n = 1'b1;
    tick();

    // Reset in the middle of SEND with both buffers full
    cons_en = 1'b0;
    exp_q.push_back({1'b0, 16'h0001});
    put(1'b0, 16'h0001);
    put(1'b1, 16'h0002);
    tick();
    check("pre_rst_send", 32'(Send_out), 32'd1);
    MR_n = 1'b0;
    #1;
    check("mid_rst_send_out", 32'(Send_out), 32'd0);
    check("mid_rst_data_out", 32'(Data_out), 32'd0);
    check("mid_rst_sel_out", 32'(SEL_out), 32'd0);
    check("mid_rst_ack_a", 32'(Ack_a), 32'd0);
    check("mid_rst_ack_b", 32'(Ack_b), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    tick(); tick();
    MR_n = 1'b1;
    tick();
    cons_en = 1'b1;
    ack_dly = 0;
    exp_q.push_back({1'b0, 16'h1234});
    put(1'b0, 16'h1234);
    drain();

    // Single-packet latency
    do_reset();
    exp_q.push_back({1'b0, 16'h00A5});
    Send_a = 1'b1;
    Data_a = 16'h00A5;
    tick();
    check("lat_ack_a", 32'(Ack_a), 32'd1);
    check("lat_send_early", 32'(Send_out), 32'd0);
    Send_a = 1'b0;
    tick();
    check("lat_send_out", 32'(Send_out), 32'd1);
    check("lat_data_out", 32'(Data_out), 32'h00A5);
    check("lat_sel_out", 32'(SEL_out), 32'd0);
    check("lat_ack_a_fall", 32'(Ack_a), 32'd0);
    drain();

    // Table-driven merge/join vectors
    do_reset();
    for (int i = 0; i < 8; i++) begin
      JNB = vecs[i].jnb;
      exp_q.push_back(vecs[i].e0);
      if (vecs[i].n_exp == 2) exp_q.push_back(vecs[i].e1);
      fork
        begin
          if (vecs[i].use_a) begin
            repeat (vecs[i].dly_a) tick();
            put(1'b0, vecs[i].da);
          end
        end
        begin
          if (vecs[i].use_b) begin
            repeat (vecs[i].dly_b) tick();
            put(1'b1, vecs[i].db);
          end
        end
      join
      drain();
      JNB = 1'b0;
    end

    // Join with B arriving early; JNB drops between the pair
    do_reset();
    ack_dly = 2;
    JNB = 1'b1;
    put(1'b1, 16'h00BB);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("join_wait_no_send", 32'(Send_out), 32'd0);
    end
    exp_q.push_back({1'b0, 16'h00AA});
    exp_q.push_back({1'b1, 16'h00BB});
    put(1'b0, 16'h00AA);
    check("join_first_sending", 32'(Send_out), 32'd1);
    JNB = 1'b0;
    drain();
    ack_dly = 0;

    // Backpressure: downstream silent for 20 cycles while A offers a second packet
    do_reset();
    cons_en = 1'b0;
    exp_q.push_back({1'b0, 16'h0055});
    exp_q.push_back({1'b0, 16'h0066});
    put(1'b0, 16'h0055);
    Send_a = 1'b1;
    Data_a = 16'h0066;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_send_out", 32'(Send_out), 32'd1);
      check("bp_data_out", 32'(Data_out), 32'h0055);
      check("bp_no_ack_a", 32'(Ack_a), 32'd0);
    end
    cons_en = 1'b1;
    begin
      int t;
      t = 0;
      while (!Ack_a && t < 200) begin tick(); t++; end
      if (t >= 200) fail_now("bp_ack_a_rise");
      Send_a = 1'b0;
      t = 0;
      while (Ack_a && t < 200) begin tick(); t++; end
      if (t >= 200) fail_now("bp_ack_a_fall");
    end
    drain();

    // Random 4-phase traffic with random JNB and downstream delays
    do_reset();
    per_ch = 1'b1;
    rand_ack = 1'b1;
    begin
      logic rdone;
      rdone = 1'b0;
      fork
        begin
          fork
            begin
              for (int i = 0; i < 150; i++) begin
                logic [W-1:0] d;
                repeat ($urandom_range(0, 3)) tick();
                d = W'($urandom);
                exp_a.push_back(d);
                put(1'b0, d);
              end
            end
            begin
              for (int i = 0; i < 150; i++) begin
                logic [W-1:0] d;
                repeat ($urandom_range(0, 3)) tick();
                d = W'($urandom);
                exp_b.push_back(d);
                put(1'b1, d);
              end
            end
          join
          rdone = 1'b1;
        end
        begin
          while (!rdone) begin
            repeat ($urandom_range(1, 15)) tick();
            JNB = 1'($urandom_range(0, 1));
          end
          JNB = 1'b0;
        end
      join
    end
    drain();
    check("rand_left_a", 32'(exp_a.size()), 32'd0);
    check("rand_left_b", 32'(exp_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
